// File: rtl/mips_pkg.sv
// mips_pkg: shared types and widths for the MIPS datapath memory side
package mips_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x WORD_W storage, synchronous write, registered read, no reset
// Ports: clk; we/wd write wd at idx; re loads rd from idx; rd holds between reads.
module dmem_array
  import mips_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [WORD_W-1:0]        wd,
  output logic [WORD_W-1:0]        rd
);
  logic [WORD_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wd;
    if (re) rd <= mem[idx];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word load/store responder that stalls the pipeline while busy
// Ports: clk; reset (active-low sync); memwrite/memtoreg request; addr byte address;
// writedata store data; readdata last load result; stall processor hold (comb);
// misaligned one-cycle flag for a rejected unaligned request.
module dmem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic              memtoreg,
  input  logic [31:0]       addr,
  input  logic [31:0]       writedata,
  output logic [WORD_W-1:0] readdata,
  output logic              stall,
  output logic              misaligned
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  dmem_state_t       state;
  logic [CW-1:0]     cnt;
  logic              op_w;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] wd_q;
  logic [WORD_W-1:0] rd;
  logic              rd_ok;
  logic              req, aligned, fire;
  assign req     = memwrite | memtoreg;
  assign aligned = addr[1:0] == 2'b00;
  // gated by reset so a reset on the final busy edge still discards the access
  assign fire    = reset && state == BUSY && cnt == '0;
  assign stall   = (state == IDLE && req && aligned) || state == BUSY;
  // the array's read register has no reset, so reset-to-zero is applied here
  assign readdata = rd_ok ? rd : '0;
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk(clk),
    .we (fire && op_w),
    .re (fire && !op_w),
    .idx(idx_q),
    .wd (wd_q),
    .rd (rd)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      misaligned <= 1'b0;
      rd_ok      <= 1'b0;
    end else begin
      misaligned <= state == IDLE && req && !aligned;
      case (state)
        IDLE: if (req && aligned) begin
          op_w  <= memwrite;
          idx_q <= addr[AW+1:2];
          wd_q  <= writedata;
          cnt   <= CW'(LATENCY - 1);
          state <= BUSY;
        end
        BUSY: if (cnt != '0) cnt <= cnt - 1'b1;
        else begin
          state <= DONE;
          if (!op_w) rd_ok <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
